dsi_pkt_framer: RTL and testbench

// - Builds MIPI DSI packets from a byte stream held in the async pixel FIFO (read side, lane-clock domain).
// - Emits header (DI, WC/data0, WC/data1, ECC), then payload popped from FIFO, then CRC16 footer, as a byte stream.
// - Sits directly downstream of the FIFO read port and upstream of the lane distributor/serializer.
//

---
 rtl/dsi_pkt_framer.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_dsi_pkt_framer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsi_pkt_framer.sv
// ---------------------------------------------------------------------------
// dsi_pkt_framer
//
// Purpose:
//   Turns a byte stream held in the pixel FIFO (read side, lane-clock domain)
//   into MIPI DSI packets. A packet is sent as a byte stream:
//     short packet : DI, data0, data1, ECC
//     long packet  : DI, WC[7:0], WC[15:8], ECC, payload..., CRC[7:0], CRC[15:8]
//   The block sits between the FIFO read port and the lane distributor.
//
// Build option:
//   DSI_PKT_CRC_EN  defined   -> footer carries CRC16-CCITT (reflected,
//                                poly 0x8408, init 0xFFFF) of the payload.
//                   undefined -> CRC logic is removed and the footer is
//                                8'h00, 8'h00 ("checksum not computed").
//   Header, ECC and payload timing are identical in both builds.
//
// Parameters:
//   WC_BITS        payload byte counter width (16 for DSI)
//
// Ports:
//   i_clk          lane-domain clock
//   i_rst          asynchronous, active-high reset
//   i_start        packet request, sampled only while idle
//   i_is_long      1 = long packet, 0 = short packet
//   i_vc           virtual channel -> DI[7:6]
//   i_data_type    DSI data type   -> DI[5:0]
//   i_word_count   long: payload byte count; short: {data1, data0}
//   o_busy         high from accepted start until done
//   o_done         one-cycle pulse after the last byte handshakes
//   i_fifo_data    FIFO head byte (fall-through)
//   i_fifo_empty   FIFO empty flag
//   o_fifo_oe      FIFO pop strobe
//   o_out_data     packet byte
//   o_out_valid    o_out_data valid
//   i_out_ready    downstream accepts when o_out_valid & i_out_ready
// ---------------------------------------------------------------------------
module dsi_pkt_framer #(
  parameter int WC_BITS = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_is_long,
  input  logic [1:0]  i_vc,
  input  logic [5:0]  i_data_type,
  input  logic [15:0] i_word_count,
  output logic        o_busy,
  output logic        o_done,
  input  logic [7:0]  i_fifo_data,
  input  logic        i_fifo_empty,
  output logic        o_fifo_oe,
  output logic [7:0]  o_out_data,
  output logic        o_out_valid,
  input  logic        i_out_ready
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_PAY  = 3'd2,
    S_FTR  = 3'd3,
    S_END  = 3'd4
  } state_t;

  localparam logic [WC_BITS-1:0] CNT_ZERO = {WC_BITS{1'b0}};
  localparam logic [WC_BITS-1:0] CNT_ONE  = {{(WC_BITS-1){1'b0}}, 1'b1};

  // DSI header ECC: modified Hamming code over the 24 header bits, P7/P6 = 0.
  function automatic logic [7:0] ecc_calc(input logic [23:0] d);
    logic [7:0] e;
    e[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^
           d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    e[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^
           d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    e[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^
           d[18] ^ d[20] ^ d[21] ^ d[22];
    e[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^
           d[19] ^ d[20] ^ d[21] ^ d[23];
    e[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^
           d[19] ^ d[20] ^ d[22] ^ d[23];
    e[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^
           d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
    e[7:6] = 2'b00;
    return e;
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_idx;
  logic [1:0]         w_idx_nxt;
  logic [WC_BITS-1:0] r_cnt;
  logic [7:0]         r_di;
  logic [15:0]        r_wc;
  logic               r_long;
  logic [7:0]         r_out_data;
  logic               r_out_valid;
  logic               r_busy;
  logic               r_done;

  logic               w_load;
  logic               w_accept;
  logic               w_emit;
  logic               w_pop;
  logic               w_finish;
  logic [7:0]         w_byte;
  logic [7:0]         w_ecc;
  logic [15:0]        w_footer;

  // The output register may take a new byte when empty or being drained.
  assign w_load = ~r_out_valid | i_out_ready;

  // Header bits: DI = [7:0], WC low = [15:8], WC high = [23:16].
  assign w_ecc = ecc_calc({r_wc, r_di});

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  // The pop is combinational so the FIFO advances on the same edge the head
  // byte is captured into the output register.
  assign o_fifo_oe   = w_pop;

`ifdef DSI_PKT_CRC_EN
  // Reflected CRC16-CCITT, one byte processed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if ((r[0] ^ d[i]) == 1'b1) begin
        r = {1'b0, r[15:1]} ^ 16'h8408;
      end else begin
        r = {1'b0, r[15:1]};
      end
    end
    return r;
  endfunction

  logic [15:0] r_crc;

  // Payload CRC accumulator: seeded on packet accept, advanced on every pop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_crc <= 16'hFFFF;
    end else if (w_accept) begin
      r_crc <= 16'hFFFF;
    end else if (w_pop) begin
      r_crc <= crc16_byte(r_crc, i_fifo_data);
    end else begin
      r_crc <= r_crc;
    end
  end

  assign w_footer = r_crc;
`else
  assign w_footer = 16'h0000;
`endif

  // State and byte-index registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state logic and selection of the byte to load.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_accept    = 1'b0;
    w_emit      = 1'b0;
    w_pop       = 1'b0;
    w_finish    = 1'b0;
    w_byte      = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_idx_nxt   = 2'd0;
          w_state_nxt = S_HDR;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_HDR: begin
        if (w_load) begin
          w_emit = 1'b1;
          case (r_idx)
            2'd0:    w_byte = r_di;
            2'd1:    w_byte = r_wc[7:0];
            2'd2:    w_byte = r_wc[15:8];
            2'd3:    w_byte = w_ecc;
            default: w_byte = 8'h00;
          endcase
          if (r_idx == 2'd3) begin
            w_idx_nxt = 2'd0;
            // A zero-length long packet goes straight to its footer.
            if (!r_long) begin
              w_state_nxt = S_END;
            end else if (r_cnt == CNT_ZERO) begin
              w_state_nxt = S_FTR;
            end else begin
              w_state_nxt = S_PAY;
            end
          end else begin
            w_idx_nxt = r_idx + 2'd1;
          end
        end else begin
          w_emit = 1'b0;
        end
      end
      S_PAY: begin
        // No byte is loaded while the FIFO is empty; the output register
        // drains and the state waits for data.
        if (w_load && !i_fifo_empty && (r_cnt != CNT_ZERO)) begin
          w_emit = 1'b1;
          w_pop  = 1'b1;
          w_byte = i_fifo_data;
          if (r_cnt == CNT_ONE) begin
            w_state_nxt = S_FTR;
          end else begin
            w_state_nxt = S_PAY;
          end
        end else begin
          w_emit = 1'b0;
        end
      end
      S_FTR: begin
        if (w_load) begin
          w_emit = 1'b1;
          if (r_idx == 2'd0) begin
            w_byte    = w_footer[7:0];
            w_idx_nxt = 2'd1;
          end else begin
            w_byte      = w_footer[15:8];
            w_idx_nxt   = 2'd0;
            w_state_nxt = S_END;
          end
        end else begin
          w_emit = 1'b0;
        end
      end
      S_END: begin
        // Wait for the final byte to be accepted before signalling done.
        if (r_out_valid && i_out_ready) begin
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_END;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = 2'd0;
      end
    endcase
  end

  // Packet fields, payload counter, output register and status flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_di        <= 8'h00;
      r_wc        <= 16'h0000;
      r_long      <= 1'b0;
      r_cnt       <= CNT_ZERO;
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_di   <= {i_vc, i_data_type};
        r_wc   <= i_word_count;
        r_long <= i_is_long;
        r_cnt  <= i_word_count[WC_BITS-1:0];
      end else if (w_pop) begin
        r_cnt <= r_cnt - CNT_ONE;
      end else begin
        r_cnt <= r_cnt;
      end

      if (w_emit) begin
        r_out_data  <= w_byte;
        r_out_valid <= 1'b1;
      end else if (w_load) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end

      if (w_accept) begin
        r_busy <= 1'b1;
      end else if (w_finish) begin
        r_busy <= 1'b0;
      end else begin
        r_busy <= r_busy;
      end

      r_done <= w_finish;
    end
  end

endmodule

// File: tb/tb_dsi_pkt_framer.sv
// ---------------------------------------------------------------------------
// tb_dsi_pkt_framer
//
// Self-checking bench for dsi_pkt_framer. A queue-based FIFO model feeds the
// payload, downstream back-pressure and FIFO empty gaps are randomised, and
// every received byte stream is compared with a reference packet built from
// the DSI packet format (ECC from parity masks, bitwise CRC16 model).
// ---------------------------------------------------------------------------
module tb_dsi_pkt_framer;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic        i_is_long;
  logic [1:0]  i_vc;
  logic [5:0]  i_data_type;
  logic [15:0] i_word_count;
  logic        o_busy;
  logic        o_done;
  logic [7:0]  i_fifo_data;
  logic        i_fifo_empty;
  logic        o_fifo_oe;
  logic [7:0]  o_out_data;
  logic        o_out_valid;
  logic        i_out_ready;

  always #5 i_clk = ~i_clk;

  dsi_pkt_framer #(.WC_BITS(16)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_is_long    (i_is_long),
    .i_vc         (i_vc),
    .i_data_type  (i_data_type),
    .i_word_count (i_word_count),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .i_fifo_data  (i_fifo_data),
    .i_fifo_empty (i_fifo_empty),
    .o_fifo_oe    (o_fifo_oe),
    .o_out_data   (o_out_data),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int n_pop, n_done, n_busy, n_oe_bad, first_valid, timed_out;

  // Each ECC bit is the parity of the header bits selected by its mask.
  function automatic logic [7:0] ecc_model(input logic [23:0] h);
    logic [23:0] masks [0:5];
    logic [7:0]  e;
    masks[0] = 24'hF12CB7;
    masks[1] = 24'hF2555B;
    masks[2] = 24'h749A6D;
    masks[3] = 24'hB8E38E;
    masks[4] = 24'hDF03F0;
    masks[5] = 24'hEFFC00;
    e = 8'h00;
    for (int i = 0; i < 6; i++) e[i] = ^(h & masks[i]);
    return e;
  endfunction

  function automatic logic [15:0] crc_model(input logic [7:0] d[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (d[k]) begin
      c = c ^ {8'h00, d[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

  task automatic build_exp(input bit lng, input logic [1:0] vc, input logic [5:0] dt,
                           input logic [15:0] wc, input logic [7:0] pay[$]);
    logic [15:0] ftr;
    exp_q.delete();
    exp_q.push_back({vc, dt});
    exp_q.push_back(wc[7:0]);
    exp_q.push_back(wc[15:8]);
    exp_q.push_back(ecc_model({wc, vc, dt}));
    if (lng) begin
      foreach (pay[k]) exp_q.push_back(pay[k]);
`ifdef DSI_PKT_CRC_EN
      ftr = crc_model(pay);
`else
      ftr = 16'h0000;
`endif
      exp_q.push_back(ftr[7:0]);
      exp_q.push_back(ftr[15:8]);
    end
  endtask

  // Drives one packet request and records the observed traffic.
  // start_mode: 0 = single pulse, 1 = held high, 2 = random re-pulsing.
  task automatic run_pkt(input bit lng, input logic [1:0] vc, input logic [5:0] dt,
                         input logic [15:0] wc, input bit stall, input bit gaps,
                         input int start_mode, input int abort_at);
    int cyc;
    bit seen_done;
    bit gap;
    rx_q.delete();
    n_pop = 0; n_done = 0; n_busy = 0; n_oe_bad = 0; first_valid = -1; timed_out = 0;
    seen_done = 1'b0;
    cyc = 0;
    i_is_long = lng; i_vc = vc; i_data_type = dt; i_word_count = wc;
    i_start = 1'b1;
    while (!seen_done && cyc < 3000) begin
      if (cyc > 0) begin
        case (start_mode)
          1:       i_start = 1'b1;
          2:       i_start = 1'($urandom_range(0, 1));
          default: i_start = 1'b0;
        endcase
      end
      i_out_ready  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      gap          = gaps && ($urandom_range(0, 2) == 0);
      i_fifo_empty = (fifo_q.size() == 0) || gap;
      i_fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
      #1;
      if (o_busy) n_busy++;
      if (o_done) begin
        n_done++;
        seen_done = 1'b1;
        i_start = 1'b0;
      end
      if (o_out_valid && first_valid < 0) first_valid = cyc;
      if (o_fifo_oe) begin
        n_pop++;
        if (i_fifo_empty) n_oe_bad++;
        else void'(fifo_q.pop_front());
      end
      if (o_out_valid && i_out_ready) rx_q.push_back(o_out_data);
      if (abort_at > 0 && rx_q.size() >= abort_at) begin
        i_start = 1'b0;
        return;
      end
      cyc++;
      @(negedge i_clk);
    end
    i_start = 1'b0;
    if (!seen_done) timed_out = 1;
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_start = 1'b0; i_is_long = 1'b0; i_vc = 2'd0; i_data_type = 6'd0;
    i_word_count = 16'h0000; i_fifo_data = 8'h00; i_fifo_empty = 1'b1; i_out_ready = 1'b1;
    repeat (3) @(negedge i_clk);
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", o_done); end
    n_checks++; if (o_fifo_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b expected 0", o_fifo_oe); end
    n_checks++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_out_valid); end
    n_checks++; if (o_out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", o_out_data); end
    i_rst = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_short_pkt;
    logic [7:0] e0 [0:3];
    logic [7:0] e1 [0:3];
    logic [7:0] none[$];
    logic [1:0] vc;
    logic [5:0] dt;
    logic [15:0] wc;
    e0[0] = 8'h05; e0[1] = 8'h11; e0[2] = 8'h00; e0[3] = 8'h36;
    e1[0] = 8'h05; e1[1] = 8'h29; e1[2] = 8'h00; e1[3] = 8'h1C;
    fifo_q.delete();
    run_pkt(1'b0, 2'd0, 6'h05, 16'h0011, 1'b0, 1'b0, 0, 0);
    n_checks++; if (timed_out !== 0) begin n_fail++; $display("FAIL short0_timeout: no done within budget"); end
    n_checks++; if (rx_q.size() !== 4) begin n_fail++; $display("FAIL short0_len: got %0d expected 4", rx_q.size()); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (k >= rx_q.size() || rx_q[k] !== e0[k]) begin
        n_fail++; $display("FAIL short0_byte%0d: got %h expected %h", k, (k < rx_q.size()) ? rx_q[k] : 8'hxx, e0[k]);
      end
    end
    n_checks++; if (n_pop !== 0) begin n_fail++; $display("FAIL short0_pops: got %0d expected 0", n_pop); end
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL short0_done: got %0d expected 1", n_done); end
    n_checks++; if (first_valid !== 2) begin n_fail++; $display("FAIL short0_latency: got %0d expected 2", first_valid); end

    run_pkt(1'b0, 2'd0, 6'h05, 16'h0029, 1'b0, 1'b0, 0, 0);
    n_checks++; if (rx_q.size() !== 4) begin n_fail++; $display("FAIL short1_len: got %0d expected 4", rx_q.size()); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (k >= rx_q.size() || rx_q[k] !== e1[k]) begin
        n_fail++; $display("FAIL short1_byte%0d: got %h expected %h", k, (k < rx_q.size()) ? rx_q[k] : 8'hxx, e1[k]);
      end
    end
    n_checks++; if (n_busy !== 5) begin n_fail++; $display("FAIL short1_busy_cycles: got %0d expected 5", n_busy); end

    for (int r = 0; r < 6; r++) begin
      vc = 2'($urandom); dt = 6'($urandom); wc = 16'($urandom);
      build_exp(1'b0, vc, dt, wc, none);
      run_pkt(1'b0, vc, dt, wc, 1'b1, 1'b0, 0, 0);
      n_checks++; if (timed_out !== 0) begin n_fail++; $display("FAIL shortr%0d_timeout: no done", r); end
      n_checks++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL shortr%0d_len: got %0d expected %0d", r, rx_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size(); k++) begin
        n_checks++;
        if (k >= rx_q.size() || rx_q[k] !== exp_q[k]) begin
          n_fail++; $display("FAIL shortr%0d_byte%0d: got %h expected %h", r, k, (k < rx_q.size()) ? rx_q[k] : 8'hxx, exp_q[k]);
        end
      end
      n_checks++; if (n_pop !== 0) begin n_fail++; $display("FAIL shortr%0d_pops: got %0d expected 0", r, n_pop); end
    end
  endtask

  task automatic test_long_zero;
    logic [7:0] none[$];
    fifo_q.delete();
    fifo_q.push_back(8'hAA);
    build_exp(1'b1, 2'd0, 6'h39, 16'h0000, none);
    run_pkt(1'b1, 2'd0, 6'h39, 16'h0000, 1'b0, 1'b0, 0, 0);
    n_checks++; if (timed_out !== 0) begin n_fail++; $display("FAIL lz_timeout: no done"); end
    n_checks++; if (rx_q.size() !== 6) begin n_fail++; $display("FAIL lz_len: got %0d expected 6", rx_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      n_checks++;
      if (k >= rx_q.size() || rx_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL lz_byte%0d: got %h expected %h", k, (k < rx_q.size()) ? rx_q[k] : 8'hxx, exp_q[k]);
      end
    end
    n_checks++; if (n_pop !== 0) begin n_fail++; $display("FAIL lz_pops: got %0d expected 0", n_pop); end
    fifo_q.delete();
  endtask

  task automatic test_long_payload;
    logic [7:0] pay[$];
    logic [1:0] vc;
    logic [5:0] dt;
    int len;
    for (int r = 0; r < 6; r++) begin
      pay.delete();
      if (r == 0) begin
        for (int k = 1; k <= 6; k++) pay.push_back(8'(k));
        vc = 2'd0; dt = 6'h39;
      end else begin
        len = $urandom_range(1, 24);
        for (int k = 0; k < len; k++) pay.push_back(8'($urandom));
        vc = 2'($urandom); dt = 6'($urandom);
      end
      fifo_q = pay;
      build_exp(1'b1, vc, dt, 16'(pay.size()), pay);
      run_pkt(1'b1, vc, dt, 16'(pay.size()), 1'b1, 1'b1, 0, 0);
      n_checks++; if (timed_out !== 0) begin n_fail++; $display("FAIL long%0d_timeout: no done", r); end
      n_checks++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL long%0d_len: got %0d expected %0d", r, rx_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size(); k++) begin
        n_checks++;
        if (k >= rx_q.size() || rx_q[k] !== exp_q[k]) begin
          n_fail++; $display("FAIL long%0d_byte%0d: got %h expected %h", r, k, (k < rx_q.size()) ? rx_q[k] : 8'hxx, exp_q[k]);
        end
      end
      n_checks++; if (n_pop !== pay.size()) begin n_fail++; $display("FAIL long%0d_pops: got %0d expected %0d", r, n_pop, pay.size()); end
      n_checks++; if (n_oe_bad !== 0) begin n_fail++; $display("FAIL long%0d_underflow: got %0d pops while empty expected 0", r, n_oe_bad); end
      n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL long%0d_done: got %0d expected 1", r, n_done); end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] pay[$];
    logic [7:0] none[$];
    for (int k = 1; k <= 6; k++) pay.push_back(8'(k));
    fifo_q = pay;
    run_pkt(1'b1, 2'd1, 6'h39, 16'd6, 1'b0, 1'b0, 0, 7);
    i_rst = 1'b1;
    #1;
    n_checks++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", o_out_valid); end
    n_checks++; if (o_fifo_oe !== 1'b0) begin n_fail++; $display("FAIL rmid_oe: got %b expected 0", o_fifo_oe); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", o_busy); end
    @(negedge i_clk);
    i_rst = 1'b0;
    fifo_q.delete();
    @(negedge i_clk);
    build_exp(1'b0, 2'd2, 6'h15, 16'hBEEF, none);
    run_pkt(1'b0, 2'd2, 6'h15, 16'hBEEF, 1'b0, 1'b0, 0, 0);
    n_checks++; if (rx_q.size() !== 4) begin n_fail++; $display("FAIL rmid_next_len: got %0d expected 4", rx_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      n_checks++;
      if (k >= rx_q.size() || rx_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL rmid_next_byte%0d: got %h expected %h", k, (k < rx_q.size()) ? rx_q[k] : 8'hxx, exp_q[k]);
      end
    end
  endtask

  task automatic test_start_hold;
    logic [7:0] pay[$];
    logic [7:0] none[$];
    int extra;
    for (int m = 1; m <= 2; m++) begin
      pay.delete();
      if (m == 2) for (int k = 0; k < 3; k++) pay.push_back(8'($urandom));
      fifo_q = pay;
      build_exp(m == 2, 2'd3, 6'h29, (m == 2) ? 16'd3 : 16'h1234, pay);
      run_pkt(m == 2, 2'd3, 6'h29, (m == 2) ? 16'd3 : 16'h1234, 1'b1, 1'b0, m, 0);
      n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL hold%0d_done: got %0d expected 1", m, n_done); end
      n_checks++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL hold%0d_len: got %0d expected %0d", m, rx_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size(); k++) begin
        n_checks++;
        if (k >= rx_q.size() || rx_q[k] !== exp_q[k]) begin
          n_fail++; $display("FAIL hold%0d_byte%0d: got %h expected %h", m, k, (k < rx_q.size()) ? rx_q[k] : 8'hxx, exp_q[k]);
        end
      end
      extra = 0;
      for (int c = 0; c < 5; c++) begin
        #1;
        if (o_busy || o_out_valid) extra++;
        @(negedge i_clk);
      end
      n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL hold%0d_second_pkt: got %0d active cycles expected 0", m, extra); end
    end
  endtask

  initial begin
    test_reset();
    test_short_pkt();
    test_long_zero();
    test_long_payload();
    test_reset_mid();
    test_start_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
